key_loader: RTL and testbench
=============================

# key_loader

Write-once key delivery stage sitting directly upstream of the locked netlist's `key` input. It receives the secret key bit-serially from the tamper-proof key store over a valid/ready link and assembles it in a private shift register. It presents it to the locked logic only as a single atomic commit. Until a complete, checked key is committed, the locked logic sees a fixed decoy key, so it produces corrupted outputs.

## Interface
Parameters:
- `KEY_W`, default 8: key width in bits; matches the locked netlist's `key` bus.
- `DECOY`, default `'0` (`KEY_W` bits): value driven on `key` before commit and after error.

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Pulse that begins a load; honoured only in IDLE.
- `ser_data`: input, 1 bit. Serial key bit, MSB first.
- `ser_valid`: input, 1 bit. `ser_data` is valid.
- `ser_ready`: output, 1 bit. Block accepts a bit this cycle.
- `key`: output, `KEY_W` bits. Key to the locked netlist.
- `key_valid`: output, 1 bit. Committed key is on `key`.
- `busy`: output, 1 bit. High in SHIFT or CHECK.
- `err`: output, 1 bit. Sticky load failure.

## Operation
- States: IDLE, SHIFT, CHECK, LOCKED, ERROR.
- Transitions:
  - IDLE → SHIFT on `start`. The bit counter and shift register clear in the same cycle.
  - SHIFT: a bit is accepted on `ser_valid && ser_ready`. The shift register shifts left and `ser_data` enters the LSB. The counter increments.
  - SHIFT → after the `KEY_W`-th accepted bit:
    - with the macro: go to CHECK, and accept exactly one more bit (the parity bit).
    - without the macro: commit directly to LOCKED.
  - CHECK → LOCKED if the parity matches; CHECK → ERROR otherwise.
  - LOCKED and ERROR are terminal. `start` is ignored in them; only `rst` leaves them.
- Commit rules:
  - `key` is a separate output register. It loads from the shift register only on the transition into LOCKED.
  - Partial keys are never visible on `key`.
  - `key_valid` = (state == LOCKED).
- ERROR: `key` stays `DECOY` and `err` = 1 until reset.
- `start` while in SHIFT or CHECK is ignored; the load continues.
- A gap in `ser_valid` stalls the load indefinitely; there is no timeout.
- Counter width is `$clog2(KEY_W+1)`. It never wraps, because it saturates at `KEY_W`.

## Timing
- Reset values:
  - state = IDLE
  - `key` = `DECOY`
  - `key_valid` = 0
  - `ser_ready` = 0
  - `busy` = 0
  - `err` = 0
- `ser_ready` is combinational from state. It is 1 in SHIFT and CHECK, and 0 elsewhere.
- `start` sampled at edge t gives `busy` = 1 and `ser_ready` = 1 from t+1.
- Without the macro, the final key bit accepted at edge t gives `key` = new value and `key_valid` = 1 at t+1, with `busy` = 0 in the same cycle.
- With the macro, the parity bit accepted at edge t gives LOCKED or ERROR outputs at t+1, so latency is one cycle after the last accepted bit in both builds.
- `rst` asserted mid-load: at the next edge, all outputs return to reset values and the partial key is discarded; the shift register is cleared.
- `rst` has priority over every other event in the same cycle.

## Configuration
- `KEY_LOADER_PARITY_EN` defined:
  - The link carries `KEY_W`+1 bits; the final bit is even parity, meaning the XOR of all key bits.
  - CHECK is live.
  - A mismatch leads to ERROR.
- `KEY_LOADER_PARITY_EN` undefined:
  - CHECK is unreachable and `err` is tied to 0.
  - The link carries exactly `KEY_W` bits.

## Structure
- Shared package `key_loader_pkg` contains:
  - the `kl_state_t` enum (IDLE, SHIFT, CHECK, LOCKED, ERROR);
  - `localparam KL_DEFAULT_KEY_W = 8`.
- One natural sub-module, `key_shift_reg`. It holds the `KEY_W`-bit shift register, the saturating counter, `full` flag, and running parity XOR. The FSM and output key register stay in `key_loader`.

## Test plan
All cases use `KEY_W`=8 and `DECOY`=0x00.
- Reset, then 20 idle cycles → `key`=0x00, `key_valid`=0, `ser_ready`=0, `err`=0 throughout.
- `start`, then 0xA5 MSB first (1,0,1,0,0,1,0,1) with `ser_valid` held high, no parity build:
  - `key`=0xA5 and `key_valid`=1 exactly one cycle after the 8th handshake;
  - `key` is 0x00 on every earlier cycle.
- Same load with `ser_valid` low for 3 cycles between bits 4 and 5 → only 8 handshakes counted; `key`=0xA5 at the same relative latency after the 8th handshake.
- Parity build, 0xA5 followed by parity bit 0 → LOCKED with `key`=0xA5. Repeat after reset with parity bit 1 → `err`=1, `key`=0x00, `key_valid`=0, and a subsequent `start` is ignored.
- `rst` pulsed after 5 bits of 0x3C, then a fresh load of 0xC3 → `key`=0xC3, with no residue of 0x3C.
- After LOCKED with 0xA5: `start` plus 8 further handshake attempts → `ser_ready`=0, `key` stays 0xA5 (write-once).

Source files
------------

// File: rtl/key_loader_pkg.sv
// Shared types and defaults for the write-once key loader.
// Parity checking is enabled by defining KEY_LOADER_PARITY_EN.
package key_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    CHECK  = 3'd2,
    LOCKED = 3'd3,
    ERROR  = 3'd4
  } kl_state_t;

  localparam int KL_DEFAULT_KEY_W = 8;

endpackage

// File: rtl/key_shift_reg.sv
// Private MSB-first assembly register with saturating bit counter and running parity.
// The parity accumulator and its port exist only when KEY_LOADER_PARITY_EN is defined.
module key_shift_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KL_DEFAULT_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] data,
  output logic [KEY_W-1:0] data_next,
  output logic             full,
  output logic             last
`ifdef KEY_LOADER_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  logic [CNT_W-1:0] count;

  // data_next lets the owner commit the key on the same edge the final bit arrives.
  assign data_next = (data << 1) | KEY_W'(bit_in);
  assign full      = (count == CNT_W'(KEY_W));
  assign last      = (count == CNT_W'(KEY_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en && !full) begin
      data  <= data_next;
      count <= count + CNT_W'(1);
    end
  end

`ifdef KEY_LOADER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      parity <= 1'b0;
    end else if (shift_en && !full) begin
      parity <= parity ^ bit_in;
    end
  end
`endif

endmodule

// File: rtl/key_loader.sv
// Write-once key delivery: serial load into a private register, atomic commit to key.
// Define KEY_LOADER_PARITY_EN to require a trailing even-parity bit before commit.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int               KEY_W = KL_DEFAULT_KEY_W,
  parameter logic [KEY_W-1:0] DECOY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_data,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  kl_state_t state, state_next;

  logic             accept;
  logic             clear;
  logic             shift_en;
  logic             load_key;
  logic             sr_full;
  logic             sr_last;
  logic [KEY_W-1:0] sr_data;
  logic [KEY_W-1:0] sr_data_next;
  logic [KEY_W-1:0] commit_val;
`ifdef KEY_LOADER_PARITY_EN
  logic             sr_parity;
`endif

  key_shift_reg #(
    .KEY_W(KEY_W)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift_en  (shift_en),
    .bit_in    (ser_data),
    .data      (sr_data),
    .data_next (sr_data_next),
    .full      (sr_full),
    .last      (sr_last)
`ifdef KEY_LOADER_PARITY_EN
    ,
    .parity    (sr_parity)
`endif
  );

  assign accept = ser_valid && ser_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    shift_en   = 1'b0;
    load_key   = 1'b0;
    commit_val = sr_data_next;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          clear      = 1'b1;
        end
      end
      SHIFT: begin
        if (accept && !sr_full) begin
          shift_en = 1'b1;
          if (sr_last) begin
`ifdef KEY_LOADER_PARITY_EN
            state_next = CHECK;
`else
            state_next = LOCKED;
            load_key   = 1'b1;
`endif
          end
        end
      end
      CHECK: begin
        commit_val = sr_data;
`ifdef KEY_LOADER_PARITY_EN
        if (accept) begin
          if (ser_data == sr_parity) begin
            state_next = LOCKED;
            load_key   = 1'b1;
          end else begin
            state_next = ERROR;
          end
        end
`else
        state_next = IDLE;
`endif
      end
      LOCKED:  state_next = LOCKED;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // The locked netlist only ever sees DECOY or a complete, checked key.
  always_ff @(posedge clk) begin
    if (rst) begin
      key <= DECOY;
    end else if (load_key) begin
      key <= commit_val;
    end
  end

  assign ser_ready = (state == SHIFT) || (state == CHECK);
  assign busy      = (state == SHIFT) || (state == CHECK);
  assign key_valid = (state == LOCKED);
`ifdef KEY_LOADER_PARITY_EN
  assign err       = (state == ERROR);
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader with a queue-based reference model of the load protocol.
// Parity scenarios run only when KEY_LOADER_PARITY_EN is defined.
module tb_key_loader;

  localparam int         KEY_W = 8;
  localparam logic [7:0] DECOY = 8'h00;
`ifdef KEY_LOADER_PARITY_EN
  localparam int NBITS = KEY_W + 1;
`else
  localparam int NBITS = KEY_W;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] key;
  logic       key_valid;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  key_loader #(
    .KEY_W(KEY_W),
    .DECOY(DECOY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .key       (key),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = waiting for start, 1 = collecting bits, 2 = key committed, 3 = failed.
  int         m_phase = 0;
  bit         m_q[$];
  logic [7:0] m_key = DECOY;

  logic [7:0] exp_key;
  logic       exp_kv, exp_rdy, exp_busy, exp_err;
  bit         stim_q[$];

  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic d);
    logic [7:0] packed_key;
    bit         par;
    rst       = r;
    start     = s;
    ser_valid = v;
    ser_data  = d;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_q.delete();
      m_key = DECOY;
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_q.delete();
      end
    end else if (m_phase == 1 && v) begin
      m_q.push_back(d);
      if (m_q.size() == NBITS) begin
        packed_key = 8'h00;
        par        = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
          packed_key = {packed_key[6:0], m_q[i]};
          par        = par ^ m_q[i];
        end
        if (NBITS > KEY_W && m_q[KEY_W] != par) begin
          m_phase = 3;
        end else begin
          m_phase = 2;
          m_key   = packed_key;
        end
      end
    end
    #1;
    exp_key  = m_key;
    exp_kv   = (m_phase == 2);
    exp_rdy  = (m_phase == 1);
    exp_busy = (m_phase == 1);
    exp_err  = (m_phase == 3);
  endtask

  task automatic build_stream(input logic [7:0] val, input bit flip);
    bit par;
    par = 1'b0;
    stim_q.delete();
    for (int i = KEY_W - 1; i >= 0; i--) begin
      stim_q.push_back(val[i]);
      par = par ^ val[i];
    end
    if (NBITS > KEY_W) stim_q.push_back(par ^ flip);
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({key, key_valid, ser_ready, busy, err} !== {DECOY, 4'b0000}) begin
      n_errors++;
      $display("[TB] FAIL reset_values: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h all flags 0",
               key, key_valid, ser_ready, busy, err, DECOY);
    end
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL idle_cycle%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                 c, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
      end
    end
  endtask

  task automatic test_load_a5();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({busy, ser_ready, key_valid} !== 3'b110) begin
      n_errors++;
      $display("[TB] FAIL start_latency: got busy=%b rdy=%b kv=%b, want 1 1 0", busy, ser_ready, key_valid);
    end
    build_stream(8'hA5, 1'b0);
    for (int i = 0; i < stim_q.size(); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, stim_q[i]);
      n_checks++;
      if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL load_a5_bit%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                 i, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
      end
    end
    n_checks++;
    if (key !== 8'hA5 || key_valid !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL load_a5_commit: got key=%h kv=%b busy=%b, want key=a5 kv=1 busy=0", key, key_valid, busy);
    end
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    build_stream(8'hA5, 1'b0);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
          n_checks++;
          if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
            n_errors++;
            $display("[TB] FAIL stall_gap%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                     g, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
          end
        end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, stim_q[i]);
      n_checks++;
      if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL stall_bit%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                 i, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
      end
    end
    n_checks++;
    if (key !== 8'hA5 || key_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL stall_commit: got key=%h kv=%b, want key=a5 kv=1", key, key_valid);
    end
  endtask

`ifdef KEY_LOADER_PARITY_EN
  task automatic test_parity();
    for (int flip = 0; flip < 2; flip++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      build_stream(8'hA5, 1'(flip));
      for (int i = 0; i < stim_q.size(); i++) begin
        applyStimulus(1'b0, 1'b0, 1'b1, stim_q[i]);
        n_checks++;
        if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
          n_errors++;
          $display("[TB] FAIL parity%0d_bit%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                   flip, i, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
        end
      end
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, (c == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      n_checks++;
      if (key !== 8'h00 || key_valid !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || ser_ready !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL parity_error_sticky%0d: got key=%h kv=%b err=%b busy=%b rdy=%b, want key=00 kv=0 err=1 busy=0 rdy=0",
                 c, key, key_valid, err, busy, ser_ready);
      end
    end
  endtask
`endif

  task automatic test_reset_midload();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    build_stream(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, stim_q[i]);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({key, key_valid, ser_ready, busy, err} !== {DECOY, 4'b0000}) begin
      n_errors++;
      $display("[TB] FAIL midload_reset: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h all flags 0",
               key, key_valid, ser_ready, busy, err, DECOY);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    build_stream(8'hC3, 1'b0);
    for (int i = 0; i < stim_q.size(); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, stim_q[i]);
      n_checks++;
      if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
        n_errors++;
        $display("[TB] FAIL reload_c3_bit%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                 i, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
      end
    end
    n_checks++;
    if (key !== 8'hC3 || key_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reload_c3_commit: got key=%h kv=%b, want key=c3 kv=1", key, key_valid);
    end
  endtask

  task automatic test_write_once();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    build_stream(8'hA5, 1'b0);
    for (int i = 0; i < stim_q.size(); i++) applyStimulus(1'b0, 1'b0, 1'b1, stim_q[i]);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      n_checks++;
      if (key !== 8'hA5 || key_valid !== 1'b1 || ser_ready !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL write_once%0d: got key=%h kv=%b rdy=%b busy=%b, want key=a5 kv=1 rdy=0 busy=0",
                 c, key, key_valid, ser_ready, busy);
      end
    end
  endtask

  task automatic test_random_loads();
    logic [7:0] val;
    for (int n = 0; n < 5; n++) begin
      val = 8'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      build_stream(val, 1'b0);
      for (int i = 0; i < stim_q.size(); i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
          n_checks++;
          if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
            n_errors++;
            $display("[TB] FAIL random%0d_gap_bit%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                     n, i, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
          end
        end
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, stim_q[i]);
        n_checks++;
        if ({key, key_valid, ser_ready, busy, err} !== {exp_key, exp_kv, exp_rdy, exp_busy, exp_err}) begin
          n_errors++;
          $display("[TB] FAIL random%0d_bit%0d: got key=%h kv=%b rdy=%b busy=%b err=%b, want key=%h kv=%b rdy=%b busy=%b err=%b",
                   n, i, key, key_valid, ser_ready, busy, err, exp_key, exp_kv, exp_rdy, exp_busy, exp_err);
        end
      end
      n_checks++;
      if (key !== val || key_valid !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL random%0d_commit: got key=%h kv=%b, want key=%h kv=1", n, key, key_valid, val);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    ser_data  = 1'b0;
    ser_valid = 1'b0;
    $display("[TB] key_loader bench, %0d link bits per load", NBITS);
    test_reset();
    test_load_a5();
    test_stall();
`ifdef KEY_LOADER_PARITY_EN
    test_parity();
`endif
    test_reset_midload();
    test_write_once();
    test_random_loads();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
